// File: rtl/addsub_seq.sv
// Multi-cycle adder/subtractor: one CHUNK-wide slice per clock, with the carry held in a register
// between slices. Provides a start/done handshake and CF/ZF/OF/NF flags that update with done.
module addsub_seq #(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] FW,
    output logic         CF,
    output logic         ZF,
    output logic         OF,
    output logic         NF
);
    localparam int NCH = N / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_opa;
    logic [N-1:0]    r_opb;
    logic [N-1:0]    r_sum;
    logic            r_carry;
    logic            r_op;
    logic [IW-1:0]   r_idx;

    int              w_base;
    logic [CHUNK-1:0] w_a_ch;
    logic [CHUNK-1:0] w_b_ch;
    logic [CHUNK-1:0] w_s;
    logic            w_c;
    logic            w_c_msb;
    logic            w_last;
    logic            w_accept;
    logic [N-1:0]    w_sum_full;

    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign w_last   = (r_idx == LAST_IDX);
    assign w_accept = start && (r_state != S_RUN);

    always_comb begin
        w_base     = int'(r_idx) * CHUNK;
        w_a_ch     = r_opa[w_base +: CHUNK];
        w_b_ch     = r_opb[w_base +: CHUNK];
        {w_c, w_s} = {1'b0, w_a_ch} + {1'b0, w_b_ch} + {{CHUNK{1'b0}}, r_carry};
        // Carry into the top bit of the slice, recovered from its sum bit.
        w_c_msb    = w_s[CHUNK-1] ^ w_a_ch[CHUNK-1] ^ w_b_ch[CHUNK-1];
        w_sum_full = r_sum;
        w_sum_full[w_base +: CHUNK] = w_s;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_opa   <= '0;
            r_opb   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_op    <= 1'b0;
            r_idx   <= '0;
            FW      <= '0;
            CF      <= 1'b0;
            ZF      <= 1'b0;
            OF      <= 1'b0;
            NF      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_opa   <= A;
                r_opb   <= op ? ~B : B;
                r_carry <= op;
                r_op    <= op;
                r_idx   <= '0;
            end else if (r_state == S_RUN) begin
                r_sum   <= w_sum_full;
                r_carry <= w_c;
                r_idx   <= w_last ? '0 : r_idx + 1'b1;
                if (w_last) begin
                    FW <= w_sum_full;
                    NF <= w_sum_full[N-1];
                    ZF <= (w_sum_full == '0);
                    CF <= r_op ^ w_c;
                    OF <= w_c_msb ^ w_c;
                end
            end
        end
    end
endmodule

// File: tb/tb_addsub_seq.sv
// Directed and random checks of addsub_seq against a plain-arithmetic reference model.
module tb_addsub_seq;
    localparam int N     = 32;
    localparam int CHUNK = 8;
    localparam int NCH   = N / CHUNK;

    logic         clk = 1'b0;
    logic         rst_n, start, op;
    logic [N-1:0] A, B, FW;
    logic         busy, done, CF, ZF, OF, NF;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    addsub_seq #(.N(N), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .done(done), .FW(FW), .CF(CF), .ZF(ZF), .OF(OF), .NF(NF)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {CF, ZF, OF, NF, FW}
    function automatic logic [N+3:0] ref_op(input logic o, input logic [N-1:0] a, input logic [N-1:0] b);
        longint sa, sb, sr;
        logic [N:0]   r;
        logic [N-1:0] fw;
        logic         cf, of;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o) begin
            fw = a - b;
            cf = (a < b);
            sr = sa - sb;
        end else begin
            r  = {1'b0, a} + {1'b0, b};
            fw = r[N-1:0];
            cf = r[N];
            sr = sa + sb;
        end
        of = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {cf, (fw == '0), of, fw[N-1], fw};
    endfunction

    task automatic run_op(input logic o, input logic [N-1:0] a, input logic [N-1:0] b,
                          input bit noise, input string tag);
        logic [N+3:0] exp;
        int cyc, nbusy;
        exp = ref_op(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;
        cyc = 0; nbusy = 0;
        while (done !== 1'b1 && cyc < 4*NCH) begin
            if (busy === 1'b1) nbusy++;
            start = noise && (cyc < NCH-1);
            A = $urandom; B = $urandom; op = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check({tag, ".latency"}, cyc, NCH);
        check({tag, ".busy_cycles"}, nbusy, NCH);
        check({tag, ".result"}, {CF, ZF, OF, NF, FW}, exp);
        check({tag, ".busy_at_done"}, busy, 1'b0);
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, done, 1'b0);
    endtask

    initial begin
        logic [N+3:0] exp;
        int cyc, ndone;
        logic [N-1:0] ra, rb;
        logic ro;

        rst_n = 1'b0; start = 1'b0; op = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.state", {busy, done}, 2'b00);
        check("reset.result", {CF, ZF, OF, NF, FW}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1-T3 directed
        run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "t1_add_wrap");
        run_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "t2_add_ovf");
        run_op(1'b1, 32'd5, 32'd7, 1'b0, "t3_sub_5_7");
        run_op(1'b1, 32'd7, 32'd5, 1'b0, "t3_sub_7_5");
        run_op(1'b1, 32'h8000_0000, 32'd1, 1'b0, "t3_sub_ovf");
        run_op(1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, "sub_equal");
        // T4: start pulses and operand churn during RUN
        run_op(1'b0, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, "t4_noise");
        run_op(1'b1, 32'h0000_00FF, 32'h0000_0100, 1'b1, "t4_noise_sub");

        // T5: reset during an operation
        run_op(1'b0, 32'h0000_1111, 32'h0000_2222, 1'b0, "t5_pre");
        @(negedge clk);
        start = 1'b1; op = 1'b0; A = 32'hAAAA_5555; B = 32'h1111_2222;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("t5.state", {busy, done}, 2'b00);
        check("t5.result", {CF, ZF, OF, NF, FW}, '0);
        rst_n = 1'b1;
        ndone = 0;
        repeat (3*NCH) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        check("t5.no_done", ndone, 0);

        // T6: start held high, back-to-back operations
        @(negedge clk);
        start = 1'b1; op = 1'b0; A = 32'd1; B = 32'd1;
        @(posedge clk); #1;
        op = 1'b1; A = 32'd3; B = 32'd3;
        cyc = 0;
        while (done !== 1'b1 && cyc < 4*NCH) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("t6.lat1", cyc, NCH);
        exp = ref_op(1'b0, 32'd1, 32'd1);
        check("t6.res1", {CF, ZF, OF, NF, FW}, exp);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                check("t6.reaccept_busy", busy, 1'b1);
                start = 1'b0;
            end
        end while (done !== 1'b1 && cyc < 4*NCH);
        check("t6.done_spacing", cyc, NCH + 1);
        exp = ref_op(1'b1, 32'd3, 32'd3);
        check("t6.res2", {CF, ZF, OF, NF, FW}, exp);
        @(posedge clk); #1;
        check("t6.idle", {busy, done}, 2'b00);

        // Random operations, with equal operands mixed in
        for (int i = 0; i < 24; i++) begin
            ro = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = (i % 4 == 0) ? ra : $urandom;
            if (i % 6 == 1) ra = 32'h8000_0000;
            run_op(ro, ra, rb, (i % 3 == 0), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
